// File: rtl/board_shuffle_ctrl.sv
// rtl/board_shuffle_ctrl.sv - card-memory shuffle sequencer: writes 8 card pairs to 16 LFSR-chosen board slots
module board_shuffle_ctrl #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [1:0]  HIDDEN_TAG = 2'b01
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Busy,
  output logic       Done,
  output logic       WriteEnable,
  output logic [3:0] dataLoc,
  output logic [5:0] dataOut
);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_LOAD  = 5'b00010,
    S_PROBE = 5'b00100,
    S_WRITE = 5'b01000,
    S_DONE  = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] used_q, used_d;
  logic [3:0]  card_idx_q, card_idx_d;
  logic [3:0]  cand_q, cand_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        we_q, we_d;
  logic [3:0]  loc_q, loc_d;
  logic [5:0]  dout_q, dout_d;

  always_comb begin
    state_d    = state_q;
    used_d     = used_q;
    card_idx_d = card_idx_q;
    cand_d     = cand_q;
    loc_d      = loc_q;
    dout_d     = dout_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        used_d     = '0;
        card_idx_d = '0;
        cand_d     = lfsr_q[3:0];
        state_d    = S_PROBE;
      end
      S_PROBE: begin
        // Linear probe: a free slot always exists while fewer than 16 are used.
        if (used_q[cand_q]) begin
          cand_d = cand_q + 4'd1;
        end else begin
          state_d = S_WRITE;
          we_d    = 1'b1;
          loc_d   = cand_q;
          dout_d  = {HIDDEN_TAG, 1'b0, card_idx_q[3:1]};
        end
      end
      S_WRITE: begin
        used_d = used_q | (16'd1 << cand_q);
        if (card_idx_q == 4'd15) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          card_idx_d = card_idx_q + 4'd1;
          cand_d     = lfsr_q[3:0];
          state_d    = S_PROBE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      used_q     <= '0;
      card_idx_q <= '0;
      cand_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      loc_q      <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      used_q     <= used_d;
      card_idx_q <= card_idx_d;
      cand_q     <= cand_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      loc_q      <= loc_d;
      dout_q     <= dout_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign WriteEnable = we_q;
  assign dataLoc     = loc_q;
  assign dataOut     = dout_q;

endmodule
